// File: rtl/gerador_instrucao_if.sv
// -----------------------------------------------------------------------------
// gerador_instrucao_if
// Configuration request and instruction-stream signals between the config
// register bank (master) and the instruction generator (slave).
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

interface gerador_instrucao_if;
  logic        iStart;
  logic [4:0]  iQtdEntradas;
  logic [2:0]  iQtdCamadas;
  logic [31:0] iCamadas;
  logic [9:0]  oInstrucao;
  logic        oFlag;
  logic        oBusy;
  logic        oDone;
  logic        oErro;

  modport master (
    output iStart, iQtdEntradas, iQtdCamadas, iCamadas,
    input  oInstrucao, oFlag, oBusy, oDone, oErro
  );

  modport slave (
    input  iStart, iQtdEntradas, iQtdCamadas, iCamadas,
    output oInstrucao, oFlag, oBusy, oDone, oErro
  );
endinterface

`default_nettype wire

// File: rtl/gerador_instrucao.sv
// -----------------------------------------------------------------------------
// gerador_instrucao
// Serialises a packed network description into N+1 10-bit instruction words,
// each presented with a flag pulse followed by a hold gap.
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module gerador_instrucao #(
  parameter int PULSE_CYC = 2,
  parameter int GAP_CYC   = 2
) (
  input  logic               clk,
  input  logic               rst,
  gerador_instrucao_if.slave bus
);

  localparam logic [3:0] PULSE_LAST = 4'(PULSE_CYC - 1);
  localparam logic [3:0] GAP_LAST   = 4'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PULSE = 3'd2,
    GAP   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      state, state_next;
  logic [2:0]  idx, idx_next;
  logic [3:0]  cnt, cnt_next;

  logic [4:0]  entradas_q;
  logic [2:0]  camadas_n_q;
  logic [31:0] camadas_q;

  logic [9:0]  instrucao;
  logic        flag, busy, done, erro;

  logic        req_valid;
  logic        accept;
  logic [7:0]  layer_byte;
  logic [9:0]  layer_word;

  // A request is usable only with 1..4 layers and at least one input.
  assign req_valid = (bus.iQtdCamadas != 3'd0) && (bus.iQtdCamadas <= 3'd4) &&
                     (bus.iQtdEntradas != 5'd0);
  assign accept    = (state == IDLE) && bus.iStart && req_valid;

  // Layer word for the index about to be set up; idx 1..N maps to layer idx-1,
  // and the final layer is tagged with type 11.
  always_comb begin
    layer_byte = 8'h00;
    case (idx_next)
      3'd1:    layer_byte = camadas_q[7:0];
      3'd2:    layer_byte = camadas_q[15:8];
      3'd3:    layer_byte = camadas_q[23:16];
      3'd4:    layer_byte = camadas_q[31:24];
      default: layer_byte = 8'h00;
    endcase
    layer_word = {((idx_next == camadas_n_q) ? 2'b11 : 2'b01), layer_byte};
  end

  // Next-state, word index and phase counter.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = SETUP;
          idx_next   = 3'd0;
          cnt_next   = 4'd0;
        end
      end
      SETUP: begin
        state_next = PULSE;
        cnt_next   = 4'd0;
      end
      PULSE: begin
        if (cnt == PULSE_LAST) begin
          state_next = GAP;
          cnt_next   = 4'd0;
        end else begin
          cnt_next = cnt + 4'd1;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_next = 4'd0;
          if (idx < camadas_n_q) begin
            state_next = SETUP;
            idx_next   = idx + 3'd1;
          end else begin
            state_next = DONE;
          end
        end else begin
          cnt_next = cnt + 4'd1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, latched configuration and registered outputs; outputs are decoded
  // from the next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= 3'd0;
      cnt         <= 4'd0;
      entradas_q  <= 5'd0;
      camadas_n_q <= 3'd0;
      camadas_q   <= 32'd0;
      instrucao   <= 10'd0;
      flag        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      erro        <= 1'b0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      cnt   <= cnt_next;
      if (accept) begin
        entradas_q  <= bus.iQtdEntradas;
        camadas_n_q <= bus.iQtdCamadas;
        camadas_q   <= bus.iCamadas;
        instrucao   <= {2'b00, bus.iQtdEntradas, 3'b000};
      end else if ((state == GAP) && (state_next == SETUP)) begin
        instrucao <= layer_word;
      end
      flag <= (state_next == PULSE);
      busy <= (state_next == SETUP) || (state_next == PULSE) || (state_next == GAP);
      done <= (state_next == DONE);
      erro <= (state == IDLE) && bus.iStart && !req_valid;
    end
  end

  assign bus.oInstrucao = instrucao;
  assign bus.oFlag      = flag;
  assign bus.oBusy      = busy;
  assign bus.oDone      = done;
  assign bus.oErro      = erro;

endmodule

`default_nettype wire

// File: tb/tb_gerador_instrucao.sv
// -----------------------------------------------------------------------------
// tb_gerador_instrucao
// Directed self-checking bench for gerador_instrucao (PULSE_CYC=GAP_CYC=2).
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_gerador_instrucao;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  // Activity recorded by the bench-side receiver model.
  logic [9:0] cap[$];
  int         rises    = 0;
  int         erro_cnt = 0;
  int         unstable = 0;
  logic       prev_flag = 1'b0;
  logic [9:0] prev_instr = 10'd0;

  gerador_instrucao_if bus();

  gerador_instrucao #(.PULSE_CYC(2), .GAP_CYC(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Receiver: captures the word on each falling flag edge, but not the one
  // caused by reset since it is reset together with the generator.
  always @(negedge bus.oFlag) if (!rst) cap.push_back(bus.oInstrucao);
  always @(posedge bus.oFlag) rises <= rises + 1;
  always @(posedge clk) if (bus.oErro) erro_cnt <= erro_cnt + 1;
  // Word must not change while the flag stays high.
  always @(negedge clk) begin
    if (bus.oFlag && prev_flag && (bus.oInstrucao !== prev_instr)) unstable <= unstable + 1;
    prev_flag  <= bus.oFlag;
    prev_instr <= bus.oInstrucao;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses iStart for one edge; returns in cycle E0+1.
  task automatic do_start();
    bus.iStart = 1'b1;
    tick();
    bus.iStart = 1'b0;
  endtask

  // Advances until oDone, returning its cycle relative to E0 (-1 on timeout).
  task automatic wait_done(input int t0, input int budget, output int t);
    t = t0;
    while (!bus.oDone && t < budget) begin
      tick();
      t++;
    end
    if (!bus.oDone) t = -1;
  endtask

  task automatic set_cfg(input logic [4:0] ent, input logic [2:0] n, input logic [31:0] cam);
    bus.iQtdEntradas = ent;
    bus.iQtdCamadas  = n;
    bus.iCamadas     = cam;
  endtask

  task automatic test_reset();
    int r0;
    tick(); tick();
    checks++; if (bus.oInstrucao !== 10'd0) begin errors++; $display("FAIL reset_instr: got %h expected 000", bus.oInstrucao); end
    checks++; if ({bus.oFlag, bus.oBusy, bus.oDone, bus.oErro} !== 4'b0) begin errors++; $display("FAIL reset_ctrl: got %b expected 0000", {bus.oFlag, bus.oBusy, bus.oDone, bus.oErro}); end
    rst = 1'b0;
    tick();
    set_cfg(5'd3, 3'd2, 32'h0000_122D);
    do_start();
    tick();
    checks++; if (bus.oFlag !== 1'b1) begin errors++; $display("FAIL reset_prep_flag: got %b expected 1", bus.oFlag); end
    #3 rst = 1'b1;
    #1;
    checks++; if ({bus.oFlag, bus.oBusy, bus.oInstrucao} !== 12'd0) begin errors++; $display("FAIL reset_async: got flag=%b busy=%b instr=%h expected 0 0 000", bus.oFlag, bus.oBusy, bus.oInstrucao); end
    tick();
    rst = 1'b0;
    r0 = rises;
    for (int i = 0; i < 12; i++) tick();
    checks++; if (rises !== r0 || bus.oBusy !== 1'b0) begin errors++; $display("FAIL reset_idle: got rises=%0d busy=%b expected rises=%0d busy=0", rises, bus.oBusy, r0); end
  endtask

  task automatic test_nominal();
    logic [9:0] exp_w[3] = '{10'h018, 10'h12D, 10'h312};
    int base, t, u0, e0;
    set_cfg(5'd3, 3'd2, 32'h0000_122D);
    base = cap.size(); u0 = unstable; e0 = erro_cnt;
    do_start();
    checks++; if (bus.oBusy !== 1'b1 || bus.oInstrucao !== 10'h018 || bus.oFlag !== 1'b0) begin errors++; $display("FAIL nom_setup: got busy=%b instr=%h flag=%b expected 1 018 0", bus.oBusy, bus.oInstrucao, bus.oFlag); end
    wait_done(1, 60, t);
    checks++; if (t !== 16) begin errors++; $display("FAIL nom_done_cycle: got %0d expected 16", t); end
    checks++; if (bus.oBusy !== 1'b0) begin errors++; $display("FAIL nom_busy_at_done: got %b expected 0", bus.oBusy); end
    checks++; if (cap.size() - base !== 3) begin errors++; $display("FAIL nom_falls: got %0d expected 3", cap.size() - base); end
    for (int i = 0; i < 3 && base + i < cap.size(); i++) begin
      checks++; if (cap[base+i] !== exp_w[i]) begin errors++; $display("FAIL nom_word%0d: got %h expected %h", i, cap[base+i], exp_w[i]); end
    end
    tick();
    checks++; if (bus.oDone !== 1'b0 || bus.oInstrucao !== 10'h312) begin errors++; $display("FAIL nom_after_done: got done=%b instr=%h expected 0 312", bus.oDone, bus.oInstrucao); end
    checks++; if (unstable !== u0 || erro_cnt !== e0) begin errors++; $display("FAIL nom_stable: got unstable=%0d erro=%0d expected %0d %0d", unstable, erro_cnt, u0, e0); end
  endtask

  task automatic test_max_layers();
    logic [9:0] exp_w[5] = '{10'h0F8, 10'h108, 10'h115, 10'h11A, 10'h3FF};
    int base, t;
    set_cfg(5'd31, 3'd4, 32'hFF1A_1508);
    base = cap.size();
    do_start();
    wait_done(1, 80, t);
    checks++; if (t !== 26) begin errors++; $display("FAIL max_done_cycle: got %0d expected 26", t); end
    checks++; if (cap.size() - base !== 5) begin errors++; $display("FAIL max_falls: got %0d expected 5", cap.size() - base); end
    for (int i = 0; i < 5 && base + i < cap.size(); i++) begin
      checks++; if (cap[base+i] !== exp_w[i]) begin errors++; $display("FAIL max_word%0d: got %h expected %h", i, cap[base+i], exp_w[i]); end
    end
    tick();
  endtask

  task automatic test_reject();
    logic [4:0] ent[3] = '{5'd3, 5'd3, 5'd0};
    logic [2:0] nn[3]  = '{3'd0, 3'd5, 3'd2};
    int r0, e0, base, t;
    r0 = rises;
    for (int k = 0; k < 3; k++) begin
      e0 = erro_cnt;
      set_cfg(ent[k], nn[k], 32'h0000_122D);
      do_start();
      checks++; if (bus.oErro !== 1'b1 || bus.oBusy !== 1'b0) begin errors++; $display("FAIL rej%0d_pulse: got erro=%b busy=%b expected 1 0", k, bus.oErro, bus.oBusy); end
      tick();
      checks++; if (bus.oErro !== 1'b0 || erro_cnt !== e0 + 1) begin errors++; $display("FAIL rej%0d_single: got erro=%b count=%0d expected 0 %0d", k, bus.oErro, erro_cnt, e0 + 1); end
      for (int i = 0; i < 4; i++) tick();
    end
    checks++; if (rises !== r0 || bus.oBusy !== 1'b0) begin errors++; $display("FAIL rej_no_flag: got rises=%0d busy=%b expected %0d 0", rises - r0, bus.oBusy, 0); end
    set_cfg(5'd7, 3'd1, 32'h0000_0027);
    base = cap.size();
    do_start();
    wait_done(1, 40, t);
    checks++; if (t !== 11 || cap.size() - base !== 2) begin errors++; $display("FAIL rej_then_valid: got done=%0d words=%0d expected 11 2", t, cap.size() - base); end
    if (cap.size() - base == 2) begin
      checks++; if (cap[base] !== 10'h038 || cap[base+1] !== 10'h327) begin errors++; $display("FAIL rej_valid_words: got %h %h expected 038 327", cap[base], cap[base+1]); end
    end
    tick();
  endtask

  task automatic test_latching();
    logic [9:0] exp_w[3] = '{10'h018, 10'h12D, 10'h312};
    int base, t, r0, e0;
    set_cfg(5'd3, 3'd2, 32'h0000_122D);
    base = cap.size(); r0 = rises; e0 = erro_cnt;
    do_start();
    for (int i = 0; i < 6; i++) tick();
    set_cfg(5'd9, 3'd3, 32'hFFFF_FFFF);
    do_start();
    wait_done(8, 60, t);
    checks++; if (t !== 16) begin errors++; $display("FAIL latch_done_cycle: got %0d expected 16", t); end
    for (int i = 0; i < 20; i++) tick();
    checks++; if (rises - r0 !== 3 || erro_cnt !== e0 || bus.oBusy !== 1'b0) begin errors++; $display("FAIL latch_no_rerun: got rises=%0d erro=%0d busy=%b expected 3 %0d 0", rises - r0, erro_cnt, bus.oBusy, e0); end
    for (int i = 0; i < 3 && base + i < cap.size(); i++) begin
      checks++; if (cap[base+i] !== exp_w[i]) begin errors++; $display("FAIL latch_word%0d: got %h expected %h", i, cap[base+i], exp_w[i]); end
    end
  endtask

  task automatic test_abort();
    int base, t, layers;
    set_cfg(5'd3, 3'd2, 32'h0000_122D);
    do_start();
    for (int i = 0; i < 6; i++) tick();
    checks++; if (bus.oFlag !== 1'b1 || bus.oInstrucao !== 10'h12D) begin errors++; $display("FAIL abort_word1: got flag=%b instr=%h expected 1 12D", bus.oFlag, bus.oInstrucao); end
    #3 rst = 1'b1;
    #1;
    checks++; if (bus.oFlag !== 1'b0 || bus.oBusy !== 1'b0) begin errors++; $display("FAIL abort_flag: got flag=%b busy=%b expected 0 0", bus.oFlag, bus.oBusy); end
    tick();
    rst = 1'b0;
    base = cap.size();
    tick(); tick();
    do_start();
    checks++; if (bus.oInstrucao !== 10'h018) begin errors++; $display("FAIL abort_restart: got %h expected 018", bus.oInstrucao); end
    wait_done(1, 60, t);
    layers = 0;
    for (int i = base; i < cap.size(); i++) if (cap[i][9:8] != 2'b00) layers++;
    checks++; if (t !== 16 || cap.size() - base !== 3 || layers !== 2) begin errors++; $display("FAIL abort_loopback: got done=%0d words=%0d layers=%0d expected 16 3 2", t, cap.size() - base, layers); end
    tick();
  endtask

  initial begin
    bus.iStart = 1'b0;
    set_cfg(5'd0, 3'd0, 32'd0);
    test_reset();
    test_nominal();
    test_max_layers();
    test_reject();
    test_latching();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
